// File: rtl/accel_pkg.sv
// Shared accelerator types.
// Vector payload type and memory op codes.
package accel_pkg;

    typedef logic [31:0] vector_data_t;

    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_FETCH = 4'b0100;

endpackage

// File: rtl/vec_mem_responder_if.sv
// Unit <-> vector store handshake bundle.
// master = unit array side, slave = responder side.
interface vec_mem_responder_if #(
    parameter int NUM_UNITS = 4
);
    import accel_pkg::*;

    logic [NUM_UNITS-1:0]      mem_request;
    logic [NUM_UNITS-1:0][3:0] mem_op_type;
    logic [NUM_UNITS-1:0][3:0] vec_index;
    logic [NUM_UNITS-1:0][3:0] mat_row;
    logic [NUM_UNITS-1:0][3:0] mat_col;
    vector_data_t [NUM_UNITS-1:0] write_data;
    logic [NUM_UNITS-1:0]      mem_grant;
    logic [NUM_UNITS-1:0]      mem_done;
    vector_data_t [NUM_UNITS-1:0] read_data;
    logic                      busy;
    logic                      err_op;
    logic                      err_overrun;

    modport master (
        output mem_request, mem_op_type, vec_index,
        output mat_row, mat_col, write_data,
        input  mem_grant, mem_done, read_data,
        input  busy, err_op, err_overrun
    );

    modport slave (
        input  mem_request, mem_op_type, vec_index,
        input  mat_row, mat_col, write_data,
        output mem_grant, mem_done, read_data,
        output busy, err_op, err_overrun
    );

endinterface

// File: rtl/vec_mem_responder.sv
// Round-robin responder serving vector load/store/fetch
// from a local register-file vector store, one access at a time.
module vec_mem_responder
    import accel_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int NUM_VECS    = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    vec_mem_responder_if.slave bus
);

    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                    state, state_d;
    logic [CW-1:0]             cnt, cnt_d;
    logic [UW-1:0]             last, cur, win, scan;
    logic                      win_vld;
    logic                      start, finish;
    logic [NUM_UNITS-1:0]      pending, grant_d, done_d;
    logic [NUM_UNITS-1:0][3:0] op_q, idx_q, row_q, col_q;
    vector_data_t [NUM_UNITS-1:0] wd_q;
    vector_data_t              mem [NUM_VECS];

    // Matrix coordinates are latched for future use only.
    logic unused_mat;
    assign unused_mat = ^{row_q, col_q};

    // Pick the first pending unit after the last winner, wrapping around.
    always_comb begin
        win     = last;
        win_vld = 1'b0;
        scan    = '0;
        for (int k = 1; k <= NUM_UNITS; k++) begin
            scan = UW'((int'(last) + k) % NUM_UNITS);
            if (!win_vld && pending[scan]) begin
                win     = scan;
                win_vld = 1'b1;
            end
        end
    end

    // Next state: grant from IDLE, count down latency, then complete.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        grant_d = '0;
        done_d  = '0;
        start   = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_vld) begin
                    grant_d[win] = 1'b1;
                    cnt_d        = CW'(MEM_LATENCY - 1);
                    state_d      = ACCESS;
                    start        = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CW'(1);
                end else begin
                    done_d[cur] = 1'b1;
                    finish      = 1'b1;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Registered handshake pulses, busy flag and arbitration pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_grant <= '0;
            bus.mem_done  <= '0;
            bus.busy      <= 1'b0;
            last          <= UW'(NUM_UNITS - 1);
            cur           <= '0;
        end else begin
            bus.mem_grant <= grant_d;
            bus.mem_done  <= done_d;
            bus.busy      <= (state_d == ACCESS);
            if (start) begin
                last <= win;
                cur  <= win;
            end
        end
    end

    // Request capture; a request on the done edge re-arms the unit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending         <= '0;
            op_q            <= '0;
            idx_q           <= '0;
            row_q           <= '0;
            col_q           <= '0;
            wd_q            <= '0;
            bus.err_overrun <= 1'b0;
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (bus.mem_request[u]) begin
                    if (!pending[u] || done_d[u]) begin
                        pending[u] <= 1'b1;
                        op_q[u]    <= bus.mem_op_type[u];
                        idx_q[u]   <= bus.vec_index[u];
                        row_q[u]   <= bus.mat_row[u];
                        col_q[u]   <= bus.mat_col[u];
                        wd_q[u]    <= bus.write_data[u];
                    end else begin
                        bus.err_overrun <= 1'b1;
                    end
                end else if (done_d[u]) begin
                    pending[u] <= 1'b0;
                end
            end
        end
    end

    // Stores write at grant; loads/fetches return data at done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VECS; i++) begin
                mem[i] <= '0;
            end
            bus.read_data <= '0;
            bus.err_op    <= 1'b0;
        end else begin
            if (start && op_q[win] == OP_STORE) begin
                mem[idx_q[win]] <= wd_q[win];
            end
            if (finish) begin
                case (op_q[cur])
                    OP_LOAD, OP_FETCH: bus.read_data[cur] <= mem[idx_q[cur]];
                    OP_STORE:          ;
                    default:           bus.err_op <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: doc/vec_mem_responder.md
# vec_mem_responder

Memory-side responder for the accelerator's unit memory interface. Accepts one-cycle request pulses from up to `NUM_UNITS` compute units and arbitrates them round-robin. Serves vector load, store and compute-fetch operations against a local register-file vector store. Returns a one-cycle grant and a one-cycle done pulse to the requesting unit. Sits between the unit array and the vector storage, as the responder end of each unit's `mem_request`/`mem_grant`/`mem_done` handshake.

## Interface
- `NUM_UNITS`, 4: number of requesting units; unit id is the array index (2 bits at the default of 4).
- `NUM_VECS`, 16: vector store entries, addressed by the 4-bit `vec_index`.
- `MEM_LATENCY`, 2: number of cycles from grant to done; legal range ≥ 1.
- `clk  in  1`: clock. One clock domain only.
- `rst  in  1`: reset, asynchronous and active-high.
- `mem_request  in  [NUM_UNITS]`: per-unit one-cycle request pulse.
- `mem_op_type  in  [NUM_UNITS][4]`: operation code. 0001 = load, 0010 = store, 0100 = compute fetch.
- `vec_index  in  [NUM_UNITS][4]`: vector address.
- `mat_row`, `mat_col`  in  [NUM_UNITS][4]: reserved; captured but not used.
- `write_data  in  [NUM_UNITS] accel_pkg::vector_data_t`: store payload.
- `mem_grant  out  [NUM_UNITS]`: one-cycle pulse when the unit's request is selected.
- `mem_done  out  [NUM_UNITS]`: one-cycle pulse when the operation completes.
- `read_data  out  [NUM_UNITS] vector_data_t`: per-unit response register.
- `busy  out  1`: high while the state machine is not in IDLE.
- `err_op  out  1`: sticky; set when an illegal op code is serviced.
- `err_overrun  out  1`: sticky; set when a request is dropped.

## Operation
- **Capture.** On each edge where `mem_request[u]` = 1 and `pending[u]` = 0:
  - set `pending[u]`;
  - latch `op`, `vec_index` and `write_data` for unit u.
  - If `pending[u]` is already 1, drop the request, keep the latched fields unchanged, and set `err_overrun`.
- **Pending clear on done.** `pending[u]` clears on the edge that raises `mem_done[u]`. A `mem_request[u]` on that same edge is accepted (set wins).
- **Arbitration.** Round-robin with pointer `last`, reset to `NUM_UNITS-1` so unit 0 has first priority. The winner is the first pending unit scanning from `last+1` with wrap-around. `last` is updated to the winner when it is granted.
- **State machine:**
  - **IDLE:** if any `pending` bit is set, pulse `mem_grant[w]`, load `cnt = MEM_LATENCY-1`, go to ACCESS. For a store, write `mem[idx] <= write_data` on this edge.
  - **ACCESS:**
    - If `cnt != 0`, decrement `cnt`.
    - Else pulse `mem_done[w]`, clear `pending[w]`, and go to IDLE.
    - For load or fetch, `read_data[w] <= mem[idx]` on the done edge.
    - For store or an illegal op, `read_data[w]` is unchanged.
    - For an illegal op, set `err_op` on the done edge.
- **Ordering.** There is one access in flight at a time. Accesses are serialized in grant order, so a load granted after a store to the same index returns the stored data.
- **Read data hold.** `read_data[u]` holds its value until the next load or fetch completes for unit u.
- **No back-to-back service.** IDLE is entered for at least one cycle between services. Maximum throughput is one operation per `MEM_LATENCY+1` cycles.
- **Reset values (asynchronous):**
  - `mem_grant`, `mem_done`, `read_data`, `busy`, `err_op`, `err_overrun` = 0.
  - `pending` = 0, `last` = `NUM_UNITS-1`, state = IDLE.
  - All `mem` entries = 0.
- **Reset mid-operation.** Reset during ACCESS aborts the operation: no `mem_done` is issued and all pending requests are lost. A store already written at grant remains cleared by the reset, because all entries reset to 0.

## Timing
- Request sampled at edge E0. `mem_grant` is high from E1 to E2. `mem_done` and `read_data` are valid from E(1+`MEM_LATENCY`) for one cycle.
- With the default latency of 2: request at E0, grant in cycle 1, done in cycle 3. Request-to-done latency is `MEM_LATENCY+1` edges when uncontended.
- `mem_grant` and `mem_done` are registered, never combinational from the inputs, and each is exactly one cycle wide.
- `busy` is registered and high from the grant edge through the done edge, inclusive.
- Contention: a unit waits at most `(NUM_UNITS-1)×(MEM_LATENCY+1)` cycles beyond its uncontended latency.

## Test plan
- **Store then load.** Unit 0 stores pattern 0x…A5 to index 3. Unit 0 then loads index 3 → grant at E1, done at E3, `read_data[0]` = 0x…A5, `err_op` = 0.
- **Simultaneous requests.** All four units load distinct indices on the same edge → grants in order 0, 1, 2, 3, each spaced 3 cycles apart. A second all-four burst → order 0, 1, 2, 3 again, since the pointer wraps.
- **Illegal op.** Unit 2 issues op 1000 → grant and done pulse, `read_data[2]` unchanged, `err_op` = 1 and stays 1 until reset.
- **Overrun.** Unit 1 requests, then requests again before its done → the second request is dropped, `err_overrun` = 1, exactly one done.
- **Reset mid-operation.** Assert reset one cycle after grant → no `mem_done`, `busy` = 0 immediately. A subsequent load of any index returns 0.
- **Compute fetch and set-wins.** Unit 3 fetches (op 0100) index 15 → returns `mem[15]`. A new request on the same edge as its done is accepted and served, with no `err_overrun`.
